// File: rtl/tube_pkg.sv
// ---------------------------------------------------------------------------
// tube_pkg
// Shared definitions for the seven-segment tube display controller:
//   - register address map (VALUE, CTRL, BLINK, DP)
//   - CTRL bit positions (EN, LZS, DEC)
//   - state type for the sequential binary-to-BCD converter
//   - hex-to-segment decoder plus the dash and blank segment codes
// Segment vectors are ordered g..a in bits [6:0].
// ---------------------------------------------------------------------------
package tube_pkg;

    // Register select values seen on iAddr
    localparam logic [1:0] ADDR_VALUE = 2'd0;
    localparam logic [1:0] ADDR_CTRL  = 2'd1;
    localparam logic [1:0] ADDR_BLINK = 2'd2;
    localparam logic [1:0] ADDR_DP    = 2'd3;

    // Bit positions inside the CTRL register
    localparam int CTRL_EN  = 0;
    localparam int CTRL_LZS = 1;
    localparam int CTRL_DEC = 2;

    // Segment codes that are not digits
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Converter state: idle, or shifting one binary bit per cycle
    typedef enum logic {
        CONV_IDLE,
        CONV_SHIFT
    } convState_e;

    // Maps a nibble to its active-high segment pattern (0-9, A, b, C, d, E, F)
    function automatic logic [6:0] hexToSeg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential shift-add-3 (double dabble) binary-to-BCD converter that handles
// one binary bit per clock. A conversion of 4*DIGITS bits keeps busy_o high
// for exactly 4*DIGITS cycles. Two extra BCD digits are carried internally so
// that values needing more than DIGITS decimal digits can be flagged.
// Ports:
//   clk_i      - clock
//   rst_i      - synchronous active-high reset / abort
//   start_i    - load value_i and (re)start, discarding any conversion in flight
//   value_i    - binary value to convert (4*DIGITS bits)
//   busy_o     - high while a conversion is running
//   done_o     - single-cycle pulse on the final shift; bcd_o/overflow_o valid
//   bcd_o      - low DIGITS BCD digits of the result (valid with done_o)
//   overflow_o - result does not fit in DIGITS decimal digits (valid with done_o)
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
    import tube_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [4*DIGITS-1:0] value_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                overflow_o
);

    localparam int BITS   = 4 * DIGITS;
    localparam int WORK_W = 4 * (DIGITS + 2);
    localparam int CNT_W  = $clog2(BITS + 1);

    convState_e        state_q, state_d;
    logic [BITS-1:0]   shift_q, shift_d;
    logic [WORK_W-1:0] work_q, work_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORK_W-1:0] adjusted;
    logic              lastStep;

    assign lastStep = (state_q == CONV_SHIFT) && (count_q == CNT_W'(BITS - 1));

    // State register plus datapath registers; an abort wins over everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CONV_IDLE;
            shift_q <= '0;
            work_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            count_q <= count_d;
        end
    end

    // Next state: a start always (re)enters SHIFT, the last bit returns to IDLE
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = CONV_SHIFT;
        end else if (lastStep) begin
            state_d = CONV_IDLE;
        end
    end

    // Add 3 to every BCD digit that is 5 or more before the next shift
    always_comb begin
        adjusted = work_q;
        for (int d = 0; d < DIGITS + 2; d++) begin
            if (work_q[4*d +: 4] >= 4'd5) begin
                adjusted[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // Datapath next values: load on start, otherwise shift one binary bit in
    always_comb begin
        shift_d = shift_q;
        work_d  = work_q;
        count_d = count_q;
        if (start_i) begin
            shift_d = value_i;
            work_d  = '0;
            count_d = '0;
        end else if (state_q == CONV_SHIFT) begin
            work_d  = {adjusted[WORK_W-2:0], shift_q[BITS-1]};
            shift_d = {shift_q[BITS-2:0], 1'b0};
            count_d = count_q + CNT_W'(1);
        end
    end

    // Outputs: the result is taken from the final shift so it is published
    // on the same edge busy falls. A restart or abort on that edge discards it.
    // A carry out of the top work digit cannot occur for these widths, but it
    // would also mean the value is too large, so it is folded into overflow.
    always_comb begin
        busy_o     = (state_q == CONV_SHIFT);
        done_o     = lastStep && !start_i && !rst_i;
        bcd_o      = work_d[BITS-1:0];
        overflow_o = (|work_d[WORK_W-1:BITS]) | adjusted[WORK_W-1];
    end

endmodule

// File: rtl/tube_display_controller.sv
// ---------------------------------------------------------------------------
// tube_display_controller
// Memory-mapped driver for multiplexed seven-segment tubes. The CPU writes
// VALUE/CTRL/BLINK/DP registers; the block scans one digit at a time with a
// fixed dwell, supporting hex or decimal display, leading-zero suppression,
// per-digit blink and per-digit decimal point.
// Ports:
//   iFpgaClk              - system clock
//   iFpgaRst              - synchronous active-high reset
//   iWriteEnable          - register write strobe
//   iAddr                 - register select: 0 VALUE, 1 CTRL, 2 BLINK, 3 DP
//   iWriteData            - write data (unused upper bits ignored)
//   oReadData             - registered readback of the iAddr register
//   oBusy                 - BCD conversion in progress
//   oDigitalTubeNotEnable - digit enables, active low
//   oDigitalTubeShape     - segments [6:0] = g..a, [7] = dp
// ---------------------------------------------------------------------------
module tube_display_controller
    import tube_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int CLK_HZ         = 100000000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLINK_HZ       = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic              iFpgaClk,
    input  logic              iFpgaRst,
    input  logic              iWriteEnable,
    input  logic [1:0]        iAddr,
    input  logic [31:0]       iWriteData,
    output logic [31:0]       oReadData,
    output logic              oBusy,
    output logic [DIGITS-1:0] oDigitalTubeNotEnable,
    output logic [7:0]        oDigitalTubeShape
);

    localparam int VAL_W   = 4 * DIGITS;
    localparam int DWELL   = CLK_HZ / SCAN_HZ;
    localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
    localparam int DWELL_W = $clog2(DWELL + 1);
    localparam int HALF_W  = $clog2(HALF + 1);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? ~{1'b0, SEG_BLANK} : {1'b0, SEG_BLANK};

    logic [VAL_W-1:0]   value_q, value_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [DIGITS-1:0]  blink_q, blink_d;
    logic [DIGITS-1:0]  dp_q, dp_d;
    logic [31:0]        readData_q, readData_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [IDX_W-1:0]   scanIdx_q, scanIdx_d;
    logic [HALF_W-1:0]  blinkCnt_q, blinkCnt_d;
    logic               phaseOn_q, phaseOn_d;
    logic [VAL_W-1:0]   bcdBuf_q, bcdBuf_d;
    logic               ovf_q, ovf_d;
    logic [DIGITS-1:0]  notEn_q, notEn_d;
    logic [7:0]         shape_q, shape_d;

    logic               convStart;
    logic               convReset;
    logic               convBusy;
    logic               convDone;
    logic [VAL_W-1:0]   convBcd;
    logic               convOvf;

    logic [VAL_W-1:0]   dispDigits;
    logic [IDX_W-1:0]   highDigit;
    logic               showDash;
    logic               blank;
    logic [6:0]         segs;

    // All state registers; reset lands every register in its idle/blank value
    always_ff @(posedge iFpgaClk) begin
        if (iFpgaRst) begin
            value_q    <= '0;
            ctrl_q     <= '0;
            blink_q    <= '0;
            dp_q       <= '0;
            readData_q <= '0;
            dwell_q    <= '0;
            scanIdx_q  <= '0;
            blinkCnt_q <= '0;
            phaseOn_q  <= 1'b1;
            bcdBuf_q   <= '0;
            ovf_q      <= 1'b0;
            notEn_q    <= '1;
            shape_q    <= SEG_OFF;
        end else begin
            value_q    <= value_d;
            ctrl_q     <= ctrl_d;
            blink_q    <= blink_d;
            dp_q       <= dp_d;
            readData_q <= readData_d;
            dwell_q    <= dwell_d;
            scanIdx_q  <= scanIdx_d;
            blinkCnt_q <= blinkCnt_d;
            phaseOn_q  <= phaseOn_d;
            bcdBuf_q   <= bcdBuf_d;
            ovf_q      <= ovf_d;
            notEn_q    <= notEn_d;
            shape_q    <= shape_d;
        end
    end

    // Register writes and readback; readback shows the registers before any
    // write on the same edge
    always_comb begin
        value_d = value_q;
        ctrl_d  = ctrl_q;
        blink_d = blink_q;
        dp_d    = dp_q;
        if (iWriteEnable) begin
            case (iAddr)
                ADDR_VALUE: value_d = iWriteData[VAL_W-1:0];
                ADDR_CTRL:  ctrl_d  = iWriteData[2:0];
                ADDR_BLINK: blink_d = iWriteData[DIGITS-1:0];
                ADDR_DP:    dp_d    = iWriteData[DIGITS-1:0];
            endcase
        end
        case (iAddr)
            ADDR_VALUE: readData_d = 32'(value_q);
            ADDR_CTRL:  readData_d = {convBusy, 28'd0, ctrl_q};
            ADDR_BLINK: readData_d = 32'(blink_q);
            ADDR_DP:    readData_d = 32'(dp_q);
        endcase
    end

    // Conversion control: a VALUE write in decimal mode or switching DEC on
    // starts a conversion of the value that will be in VALUE after this edge.
    // Leaving decimal mode holds the converter idle.
    assign convStart = iWriteEnable &&
                       (((iAddr == ADDR_VALUE) && ctrl_q[CTRL_DEC]) ||
                        ((iAddr == ADDR_CTRL) && !ctrl_q[CTRL_DEC] && iWriteData[CTRL_DEC]));
    assign convReset = iFpgaRst || !ctrl_d[CTRL_DEC];

    bin_to_bcd_seq #(
        .DIGITS(DIGITS)
    ) u_bcd (
        .clk_i     (iFpgaClk),
        .rst_i     (convReset),
        .start_i   (convStart),
        .value_i   (value_d),
        .busy_o    (convBusy),
        .done_o    (convDone),
        .bcd_o     (convBcd),
        .overflow_o(convOvf)
    );

    // The displayed BCD buffer only changes when a conversion completes, so
    // the tubes never show a half-converted number
    always_comb begin
        bcdBuf_d = bcdBuf_q;
        ovf_d    = ovf_q;
        if (convDone) begin
            bcdBuf_d = convBcd;
            ovf_d    = convOvf;
        end
    end

    // Dwell counter drives the scan index; an independent free-running
    // counter toggles the blink phase
    always_comb begin
        dwell_d    = dwell_q + DWELL_W'(1);
        scanIdx_d  = scanIdx_q;
        blinkCnt_d = blinkCnt_q + HALF_W'(1);
        phaseOn_d  = phaseOn_q;
        if (dwell_q == DWELL_W'(DWELL - 1)) begin
            dwell_d   = '0;
            scanIdx_d = (scanIdx_q == IDX_W'(DIGITS - 1)) ? '0 : scanIdx_q + IDX_W'(1);
        end
        if (blinkCnt_q == HALF_W'(HALF - 1)) begin
            blinkCnt_d = '0;
            phaseOn_d  = !phaseOn_q;
        end
    end

    // Digit rendering for the current scan index. Leading-zero suppression
    // blanks digits above the highest nonzero one (digit 0 always survives)
    // and is ignored while the overflow dash is shown.
    always_comb begin
        dispDigits = ctrl_q[CTRL_DEC] ? bcdBuf_q : value_q;
        showDash   = ctrl_q[CTRL_DEC] && ovf_q;
        highDigit  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dispDigits[4*i +: 4] != 4'd0) begin
                highDigit = IDX_W'(i);
            end
        end
        blank = !ctrl_q[CTRL_EN] ||
                (!phaseOn_q && blink_q[scanIdx_q]) ||
                (ctrl_q[CTRL_LZS] && !showDash && (scanIdx_q > highDigit));
        segs    = showDash ? SEG_DASH : hexToSeg(dispDigits[{scanIdx_q, 2'b00} +: 4]);
        notEn_d = '1;
        shape_d = SEG_OFF;
        if (!blank) begin
            notEn_d[scanIdx_q] = 1'b0;
            shape_d = {dp_q[scanIdx_q], segs} ^ {8{SEG_ACTIVE_LOW}};
        end
    end

    assign oReadData             = readData_q;
    assign oBusy                 = convBusy;
    assign oDigitalTubeNotEnable = notEn_q;
    assign oDigitalTubeShape     = shape_q;

endmodule
